// File: rtl/hls_stream_pkg.sv
// hls_stream_pkg
//   Shared constants and types for the stream packer FIFO slice.
//   - DEF_* : default parameter values for the packer, FIFO and counter.
//   - cnt_flags_t : transfer counter plus sticky done flag. The counter field
//     is sized for the widest supported counter. Narrower instances saturate
//     at their own all-ones value, so the upper bits stay zero.
//   - cnt_all_ones() : saturation value for a counter of a given width.
package hls_stream_pkg;

   localparam int DEF_IN_W  = 8;
   localparam int DEF_RATIO = 4;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_CNT_W = 16;

   // Widest transfer counter the struct can carry.
   localparam int CNT_MAX_W = 64;

   typedef struct packed {
      logic [CNT_MAX_W-1:0] cnt;
      logic                 done;
   } cnt_flags_t;

   function automatic logic [CNT_MAX_W-1:0] cnt_all_ones(input int width);
      if (width >= CNT_MAX_W) begin
         return '1;
      end
      return (CNT_MAX_W'(1) << width) - CNT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/hls_stream_pack_fifo_if.sv
// hls_stream_pack_fifo_if
//   Bundles the two stream handshakes of the packer FIFO.
//   - Input side: in_data_i / in_valid_i go from the producer, and
//     in_ready_o comes back from the packer.
//   - Output side: out_data_o / out_strb_o / out_valid_o go from the packer,
//     and out_ready_i comes back from the consumer.
//   Modports:
//   - slave  : the packer's view.
//   - master : the surrounding logic's view (producer and consumer).
interface hls_stream_pack_fifo_if
   import hls_stream_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int RATIO = DEF_RATIO
);
   localparam int OUT_W  = IN_W * RATIO;
   localparam int STRB_W = OUT_W / 8;

   logic [IN_W-1:0]   in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [OUT_W-1:0]  out_data_o;
   logic [STRB_W-1:0] out_strb_o;
   logic              out_valid_o;
   logic              out_ready_i;

   modport slave (
      input  in_data_i,
      input  in_valid_i,
      output in_ready_o,
      output out_data_o,
      output out_strb_o,
      output out_valid_o,
      input  out_ready_i
   );

   modport master (
      output in_data_i,
      output in_valid_i,
      input  in_ready_o,
      input  out_data_o,
      input  out_strb_o,
      input  out_valid_o,
      output out_ready_i
   );

endinterface

// File: rtl/hls_stream_fifo.sv
// hls_stream_fifo
//   Generic synchronous first-word-fall-through FIFO.
//   - The head word is visible on data_o the cycle after it is written.
//   - data_o reads as zero while the FIFO is empty.
//   Ports:
//   - clk_i, rst_ni : clock; asynchronous active-low reset.
//   - clear_i       : synchronous empty; wins over push and pop.
//   - push_i, data_i: write request and data; ignored when full.
//   - pop_i         : remove the head word; ignored when empty.
//   - data_o        : head word.
//   - full_o, empty_o, fill_o : status and occupancy in words.
module hls_stream_fifo
   import hls_stream_pkg::*;
#(
   parameter int WIDTH = DEF_IN_W,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      fill_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Pointers carry one extra wrap bit, which distinguishes full from empty.
   logic [AW:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0] rd_ptr_reg, rd_ptr_next;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wr_ptr_reg == rd_ptr_reg);
   assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign fill_o  = wr_ptr_reg - rd_ptr_reg;

   assign do_push = push_i & ~full_o & ~clear_i;
   assign do_pop  = pop_i & ~empty_o & ~clear_i;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (clear_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (do_push) begin
            wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage is not reset; stale entries are never exposed because data_o
   // is forced to zero while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= data_i;
      end
   end

   assign data_o = empty_o ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/hls_stream_pack_fifo.sv
// hls_stream_pack_fifo
//   Packs RATIO input beats, LSB lane first, into one output word. The packed
//   words are buffered in an FWFT FIFO. A flush emits a partial word with
//   byte enables for the filled lanes only. A transfer counter counts output
//   handshakes since start_i and raises a sticky done flag once the count
//   reaches len_i.
//   Ports:
//   - clk_i, rst_ni : clock; asynchronous active-low reset.
//   - clear_i  : synchronous clear of FIFO, packer and counter.
//   - enable_i : input acceptance gate; the FIFO keeps draining when low.
//   - start_i, len_i : start a counting transfer of len_i output words.
//   - flush_i  : emit the current partial word, if any.
//   - stream   : input beat and output word handshakes.
//   - fill_o   : FIFO occupancy in words.
//   - cnt_o, done_o : output handshakes since start, and transfer done.
module hls_stream_pack_fifo
   import hls_stream_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int RATIO = DEF_RATIO,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     enable_i,
   input  logic                     start_i,
   input  logic [CNT_W-1:0]         len_i,
   input  logic                     flush_i,
   hls_stream_pack_fifo_if.slave    stream,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic [CNT_W-1:0]         cnt_o,
   output logic                     done_o
);

   localparam int OUT_W  = IN_W * RATIO;
   localparam int STRB_W = OUT_W / 8;
   localparam int BPL    = IN_W / 8;
   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int FW     = STRB_W + OUT_W;
   localparam logic [CNT_MAX_W-1:0] CNT_SAT = cnt_all_ones(CNT_W);

   // ---------------------------------------------------------------- packer
   logic [LANE_W-1:0] lane_reg, lane_next;
   logic [OUT_W-1:0]  word_reg, word_next;
   logic              pending_reg, pending_next;

   logic              in_ready;
   logic              in_hs;
   logic              out_hs;
   logic              word_complete;
   logic [LANE_W:0]   lane_cnt;
   logic [OUT_W-1:0]  merged_word;
   logic [RATIO-1:0]  lane_mask;
   logic [STRB_W-1:0] partial_strb;

   logic              push;
   logic [FW-1:0]     push_data;
   logic [FW-1:0]     head_data;
   logic              fifo_full;
   logic              fifo_empty;

   assign in_ready          = enable_i & ~fifo_full & ~pending_reg;
   assign stream.in_ready_o = in_ready;
   assign in_hs             = stream.in_valid_i & in_ready;

   // Lanes filled once this cycle's beat (if any) is taken into account.
   assign lane_cnt      = {1'b0, lane_reg} + (LANE_W+1)'(in_hs);
   assign word_complete = in_hs && (lane_reg == LANE_W'(RATIO-1));

   // Unfilled lanes of word_reg are always zero, so the merged word is also
   // the correctly zero-padded partial word.
   genvar gi;
   for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign merged_word[gi*IN_W +: IN_W] =
         (in_hs && (lane_reg == LANE_W'(gi))) ? stream.in_data_i
                                              : word_reg[gi*IN_W +: IN_W];
      assign lane_mask[gi] = ((LANE_W+1)'(gi) < lane_cnt);
      assign partial_strb[gi*BPL +: BPL] = {BPL{lane_mask[gi]}};
   end

   always_comb begin
      lane_next    = lane_reg;
      word_next    = word_reg;
      pending_next = pending_reg;
      push         = 1'b0;
      push_data    = '0;
      if (clear_i) begin
         lane_next    = '0;
         word_next    = '0;
         pending_next = 1'b0;
      end else if (word_complete) begin
         // A beat that completes the word absorbs any flush this cycle.
         push      = 1'b1;
         push_data = {{STRB_W{1'b1}}, merged_word};
         lane_next = '0;
         word_next = '0;
      end else begin
         lane_next = lane_cnt[LANE_W-1:0];
         word_next = merged_word;
         if ((flush_i | pending_reg) && (lane_cnt != '0)) begin
            if (!fifo_full) begin
               push         = 1'b1;
               push_data    = {partial_strb, merged_word};
               lane_next    = '0;
               word_next    = '0;
               pending_next = 1'b0;
            end else begin
               // Hold the flush until the FIFO has room; input stays blocked.
               pending_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_reg    <= '0;
         word_reg    <= '0;
         pending_reg <= 1'b0;
      end else begin
         lane_reg    <= lane_next;
         word_reg    <= word_next;
         pending_reg <= pending_next;
      end
   end

   // ----------------------------------------------------------------- FIFO
   hls_stream_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (out_hs),
      .data_o  (head_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .fill_o  (fill_o)
   );

   assign stream.out_valid_o = ~fifo_empty;
   assign stream.out_data_o  = head_data[OUT_W-1:0];
   assign stream.out_strb_o  = head_data[FW-1:OUT_W];
   assign out_hs             = stream.out_valid_o & stream.out_ready_i;

   // -------------------------------------------------------- transfer count
   cnt_flags_t cf_reg, cf_next;
   // Done may only be raised for a transfer that has actually been started.
   logic       active_reg, active_next;

   always_comb begin
      cf_next     = cf_reg;
      active_next = active_reg;
      if (clear_i) begin
         cf_next     = '0;
         active_next = 1'b0;
      end else if (start_i) begin
         cf_next.cnt  = '0;
         cf_next.done = 1'b0;
         active_next  = 1'b1;
      end else begin
         if (out_hs && (cf_reg.cnt != CNT_SAT)) begin
            cf_next.cnt = cf_reg.cnt + CNT_MAX_W'(1);
         end
         // Compare the registered count, so done trails cnt_o by one cycle.
         if (active_reg && (cf_reg.cnt == CNT_MAX_W'(len_i))) begin
            cf_next.done = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cf_reg     <= '0;
         active_reg <= 1'b0;
      end else begin
         cf_reg     <= cf_next;
         active_reg <= active_next;
      end
   end

   assign cnt_o  = cf_reg.cnt[CNT_W-1:0];
   assign done_o = cf_reg.done;

endmodule
